mipi_tx_2lane_seq: RTL

MIPI_TX_2LANE_SEQ -- requirements
Module: mipi_tx_2lane_seq

---
 rtl/mipi_pkg.sv | 46 ++++
 rtl/mipi_tx_lane.sv | 60 ++++++
 rtl/mipi_tx_2lane_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mipi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mipi_pkg
// Description : Shared definitions for the two-lane MIPI D-PHY HS transmit
//               sequencer: sequencer states, per-lane byte-register commands,
//               the HS sync byte, LP line level encodings and the timer-load
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mipi_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,   // LP-11
        ST_RQST  = 3'd1,   // LP-01
        ST_PREP  = 3'd2,   // LP-00
        ST_ZERO  = 3'd3,   // HS-zero
        ST_SYNC  = 3'd4,   // HS sync byte
        ST_DATA  = 3'd5,   // HS payload
        ST_TRAIL = 3'd6,   // HS trail
        ST_EXIT  = 3'd7    // LP-11, minimum hold
    } state_e;

    // Command applied to a lane's serializer byte register at the next edge
    typedef enum logic [2:0] {
        CMD_HOLD  = 3'd0,
        CMD_ZERO  = 3'd1,
        CMD_SYNC  = 3'd2,
        CMD_WORD  = 3'd3,
        CMD_TRAIL = 3'd4
    } lane_cmd_e;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // LP line levels, packed as {LPP, LPN}
    localparam logic [1:0] LP_11 = 2'b11;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_00 = 2'b00;

    // Down-counter load value for a duration in cycles; 0 behaves as 1
    function automatic logic [7:0] timer_load(input int unsigned cyc);
        return (cyc == 0) ? 8'd0 : 8'(cyc - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mipi_tx_lane.sv
`default_nettype none
// ============================================================================
// Module      : mipi_tx_lane
// Description : Per-lane serializer byte register. Holds the byte presented
//               to the serializer and bit 7 of the lane's last payload byte,
//               from which the trail byte {8{~b7}} is formed.
// Ports       : clk_i   - HS byte clock
//               rst_n_i - asynchronous active-low reset
//               cmd_i   - register command for the next edge
//               byte_i  - payload byte for CMD_WORD
//               byte_o  - serializer byte (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module mipi_tx_lane
    import mipi_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  lane_cmd_e  cmd_i,
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    logic [7:0] byte_q, byte_d;
    logic       b7_q, b7_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            byte_q <= 8'h00;
            b7_q   <= 1'b0;
        end else begin
            byte_q <= byte_d;
            b7_q   <= b7_d;
        end
    end

    // b7 is cleared outside a burst so a lane that never carried a valid
    // byte trails with 0xFF.
    always_comb begin
        byte_d = byte_q;
        b7_d   = b7_q;
        case (cmd_i)
            CMD_ZERO: begin
                byte_d = 8'h00;
                b7_d   = 1'b0;
            end
            CMD_SYNC:  byte_d = SYNC_BYTE;
            CMD_WORD: begin
                byte_d = byte_i;
                b7_d   = byte_i[7];
            end
            CMD_TRAIL: byte_d = {8{~b7_q}};
            default:   byte_d = byte_q;
        endcase
    end

    assign byte_o = byte_q;

endmodule
`default_nettype wire

// File: rtl/mipi_tx_2lane_seq.sv
`default_nettype none
// ============================================================================
// Module      : mipi_tx_2lane_seq
// Description : Two-lane MIPI D-PHY HS transmit sequencer. Drives the LP
//               entry sequence (LP-11, LP-01, LP-00), HS-zero, sync byte,
//               payload, per-lane trail and LP-11 exit.
//               Each state loads its byte into the lane registers, so the
//               serializer byte trails the state by one cycle: the sync byte
//               is visible in the first DATA cycle and an accepted word in
//               the cycle after acceptance.
// Ports       : CLKHSBYTE  - HS byte clock        RSTN       - async reset, low
//               PU         - power-up, low aborts TXREQHS    - burst request
//               TXDATA     - {lane1, lane0} bytes  TXLANE1VLD - lane-1 valid
//               TXREADYHS  - word accepted when high with TXREQHS
//               DxTXLPP/N  - LP levels   DxTXLPEN - LP enable
//               DxTXHSEN   - HS enable   DxHSTXDATA - serializer bytes
// Options     : MIPI_TX_CLKLANE_EN adds clock-lane outputs CLKTXLPP,
//               CLKTXLPN, CLKTXLPEN and CLKTXHSEN.
// Revision    : 1.0 - initial release
// ============================================================================
module mipi_tx_2lane_seq
    import mipi_pkg::*;
#(
    parameter int unsigned TLPX_CYC     = 4,
    parameter int unsigned THSPREP_CYC  = 2,
    parameter int unsigned THSZERO_CYC  = 6,
    parameter int unsigned THSTRAIL_CYC = 3,
    parameter int unsigned THSEXIT_CYC  = 4
) (
    input  logic        CLKHSBYTE,
    input  logic        RSTN,
    input  logic        PU,
    input  logic        TXREQHS,
    input  logic [15:0] TXDATA,
    input  logic        TXLANE1VLD,
    output logic        TXREADYHS,
    output logic        D0TXLPP,
    output logic        D0TXLPN,
    output logic        D1TXLPP,
    output logic        D1TXLPN,
    output logic        D0TXLPEN,
    output logic        D1TXLPEN,
    output logic        D0TXHSEN,
    output logic        D1TXHSEN,
`ifdef MIPI_TX_CLKLANE_EN
    output logic        CLKTXLPP,
    output logic        CLKTXLPN,
    output logic        CLKTXLPEN,
    output logic        CLKTXHSEN,
`endif
    output logic [7:0]  D0HSTXDATA,
    output logic [7:0]  D1HSTXDATA
);

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    lane_cmd_e  lane0_cmd, lane1_cmd;
    logic       lp_en, hs_en;
    logic [1:0] lp_lvl;
    logic [7:0] lane0_byte, lane1_byte;

    always_ff @(posedge CLKHSBYTE or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            timer_q <= 8'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = (timer_q == 8'd0) ? 8'd0 : timer_q - 8'd1;
        lane0_cmd = CMD_ZERO;
        lane1_cmd = CMD_ZERO;
        lp_en     = 1'b1;
        lp_lvl    = LP_11;
        hs_en     = 1'b0;
        TXREADYHS = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (TXREQHS) begin
                    state_d = ST_RQST;
                    timer_d = timer_load(TLPX_CYC);
                end
            end
            ST_RQST: begin
                lp_lvl = LP_01;
                if (timer_q == 8'd0) begin
                    state_d = ST_PREP;
                    timer_d = timer_load(THSPREP_CYC);
                end
            end
            ST_PREP: begin
                lp_lvl = LP_00;
                if (timer_q == 8'd0) begin
                    state_d = ST_ZERO;
                    timer_d = timer_load(THSZERO_CYC);
                end
            end
            ST_ZERO: begin
                lp_en  = 1'b0;
                lp_lvl = LP_00;
                hs_en  = 1'b1;
                if (timer_q == 8'd0) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                lp_en     = 1'b0;
                lp_lvl    = LP_00;
                hs_en     = 1'b1;
                lane0_cmd = CMD_SYNC;
                lane1_cmd = CMD_SYNC;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                lp_en  = 1'b0;
                lp_lvl = LP_00;
                hs_en  = 1'b1;
                if (TXREQHS) begin
                    TXREADYHS = PU;
                    lane0_cmd = CMD_WORD;
                    // An invalid lane-1 byte marks the last word: lane 1
                    // moves to its trail byte one cycle ahead of lane 0.
                    lane1_cmd = TXLANE1VLD ? CMD_WORD : CMD_TRAIL;
                end else begin
                    lane0_cmd = CMD_TRAIL;
                    lane1_cmd = CMD_TRAIL;
                    state_d   = ST_TRAIL;
                    timer_d   = timer_load(THSTRAIL_CYC);
                end
            end
            ST_TRAIL: begin
                lp_en     = 1'b0;
                lp_lvl    = LP_00;
                hs_en     = 1'b1;
                lane0_cmd = CMD_HOLD;
                lane1_cmd = CMD_HOLD;
                if (timer_q == 8'd0) begin
                    state_d = ST_EXIT;
                    timer_d = timer_load(THSEXIT_CYC);
                end
            end
            ST_EXIT: begin
                if (timer_q == 8'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Power-down abort takes priority: no trail is sent.
        if (!PU) begin
            state_d = ST_IDLE;
            timer_d = 8'd0;
        end
    end

    mipi_tx_lane u_lane0 (
        .clk_i   (CLKHSBYTE),
        .rst_n_i (RSTN),
        .cmd_i   (lane0_cmd),
        .byte_i  (TXDATA[7:0]),
        .byte_o  (lane0_byte)
    );

    mipi_tx_lane u_lane1 (
        .clk_i   (CLKHSBYTE),
        .rst_n_i (RSTN),
        .cmd_i   (lane1_cmd),
        .byte_i  (TXDATA[15:8]),
        .byte_o  (lane1_byte)
    );

    assign D0TXLPP    = lp_lvl[1];
    assign D0TXLPN    = lp_lvl[0];
    assign D1TXLPP    = lp_lvl[1];
    assign D1TXLPN    = lp_lvl[0];
    assign D0TXLPEN   = lp_en;
    assign D1TXLPEN   = lp_en;
    assign D0TXHSEN   = hs_en;
    assign D1TXHSEN   = hs_en;
    assign D0HSTXDATA = hs_en ? lane0_byte : 8'h00;
    assign D1HSTXDATA = hs_en ? lane1_byte : 8'h00;

`ifdef MIPI_TX_CLKLANE_EN
    // Clock lane follows the data-lane LP levels and enters HS one state
    // early so it is running before the data lanes leave LP-00.
    assign CLKTXLPP  = lp_lvl[1];
    assign CLKTXLPN  = lp_lvl[0];
    assign CLKTXLPEN = lp_en;
    assign CLKTXHSEN = hs_en | (state_q == ST_PREP);
`endif

endmodule
`default_nettype wire
